stage_memory: RTL and testbench

Fourth pipeline stage. It sits directly downstream of the execute stage and consumes that stage's registered outputs. It resolves jumps and branches into a fetch redirect, performs data-memory loads and stores over a req/ack bus, and formats load data. It hands completed results to the writeback stage, asserting `mem_stall` to freeze execute while an access is outstanding.

---
 rtl/stage_memory.sv | 231 +++++++++++++++++++++++
 tb/tb_stage_memory.sv | 411 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stage_memory.sv
// ---------------------------------------------------------------------------
// stage_memory
//
// Fourth pipeline stage, fed directly by the execute stage's registered
// outputs. It does three jobs:
//   * resolves jumps/branches into a combinational fetch redirect,
//   * runs data-memory loads and stores over a req/ack bus, freezing
//     execute through mem_stall while an access is outstanding,
//   * formats load data and hands completed results to writeback.
//
// Ports
//   clk, reset_n              clock, synchronous active-low reset
//   mem_valid                 instruction present from execute
//   mem_pc                    instruction PC (fault reporting only)
//   mem_data0                 ALU result: address / compare bit / PC+4
//   mem_data1                 jump/branch target, otherwise store data
//   mem_read, mem_write       load / store
//   mem_extend                loads: 1 sign-extend, 0 zero-extend
//   mem_width                 0 byte, 1 half, 2/3 word
//   mem_jmp, mem_br           jump / conditional branch
//   mem_br_inv                invert branch condition
//   wb_reg                    destination register, 0 = no write
//   mem_stall                 hold execute outputs
//   br_taken, br_target       fetch redirect
//   mem_fault, fault_pc       one-cycle misalignment pulse and its PC
//   dmem_req .. dmem_wstrb    data-memory request bus (registered)
//   dmem_ack, dmem_rdata      data-memory completion and read data
//   wb_valid, wb_rd, wb_data  registered writeback result
// ---------------------------------------------------------------------------
module stage_memory (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        mem_valid,
  input  logic [31:0] mem_pc,
  input  logic [31:0] mem_data0,
  input  logic [31:0] mem_data1,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic        mem_extend,
  input  logic [1:0]  mem_width,
  input  logic        mem_jmp,
  input  logic        mem_br,
  input  logic        mem_br_inv,
  input  logic [4:0]  wb_reg,
  output logic        mem_stall,
  output logic        br_taken,
  output logic [31:0] br_target,
  output logic        mem_fault,
  output logic [31:0] fault_pc,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_wstrb,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  state_t      state;
  state_t      next_state;
  logic        squash_q;

  logic        live;
  logic        is_mem;
  logic        misaligned;
  logic        issue;
  logic        ack_done;
  logic        fault_now;
  logic        complete;
  logic        wb_write;

  logic [31:0] store_wdata;
  logic [3:0]  store_wstrb;
  logic [7:0]  load_byte;
  logic [15:0] load_half;
  logic [31:0] load_data;

  // The instruction right behind a taken jump/branch is wrong-path and is
  // killed by squash_q for exactly one cycle.
  assign live   = mem_valid & ~squash_q;
  assign is_mem = mem_read | mem_write;

  // Width 3 is treated as word, so bit 1 alone selects the word check.
  assign misaligned = is_mem & ((mem_width == 2'd1) ? mem_data0[0]
                                : (mem_width[1] & (mem_data0[1:0] != 2'b00)));

  assign issue     = live & is_mem & ~misaligned & (state == IDLE);
  assign ack_done  = (state == WAIT) & dmem_ack;
  assign fault_now = live & misaligned;

  // Stall drops in the ack cycle so execute advances on that same edge.
  assign mem_stall = live & is_mem & ~misaligned & ~ack_done;

  assign br_taken  = live & (mem_jmp | (mem_br & (mem_data0[0] ^ mem_br_inv)));
  assign br_target = mem_data1 & ~32'h1;

  // Non-memory ops complete in their single cycle here; memory ops complete
  // in the ack cycle. Stores complete but never write a register.
  assign complete = live & ~misaligned & (is_mem ? ack_done : 1'b1);
  assign wb_write = complete & ~mem_write;

  // Store data is replicated across lanes so the memory only needs strobes.
  always_comb begin
    store_wdata = mem_data1;
    store_wstrb = 4'b1111;
    case (mem_width)
      2'd0: begin
        store_wdata = {4{mem_data1[7:0]}};
        store_wstrb = 4'b0001 << mem_data0[1:0];
      end
      2'd1: begin
        store_wdata = {2{mem_data1[15:0]}};
        store_wstrb = mem_data0[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        store_wdata = mem_data1;
        store_wstrb = 4'b1111;
      end
    endcase
  end

  // Load lane selection and extension. Execute is frozen during WAIT, so the
  // address and width inputs still describe the outstanding load at ack.
  always_comb begin
    load_byte = dmem_rdata[7:0];
    case (mem_data0[1:0])
      2'd0:    load_byte = dmem_rdata[7:0];
      2'd1:    load_byte = dmem_rdata[15:8];
      2'd2:    load_byte = dmem_rdata[23:16];
      default: load_byte = dmem_rdata[31:24];
    endcase
    load_half = mem_data0[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    case (mem_width)
      2'd0:    load_data = mem_extend ? {{24{load_byte[7]}}, load_byte}
                                      : {24'h000000, load_byte};
      2'd1:    load_data = mem_extend ? {{16{load_half[15]}}, load_half}
                                      : {16'h0000, load_half};
      default: load_data = dmem_rdata;
    endcase
  end

  // State register for the memory-access FSM.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic: IDLE issues an aligned live access, WAIT holds until
  // the memory acknowledges it.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (issue) begin
          next_state = WAIT;
        end
      end
      WAIT: begin
        if (dmem_ack) begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Data-memory bus registers. Everything is captured at the issue edge and
  // held untouched through WAIT; only dmem_req changes, dropping after ack.
  // Reset abandons an outstanding request.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= 32'h0;
      dmem_wdata <= 32'h0;
      dmem_wstrb <= 4'h0;
    end else if (issue) begin
      dmem_req   <= 1'b1;
      dmem_we    <= mem_write;
      dmem_addr  <= {mem_data0[31:2], 2'b00};
      dmem_wdata <= store_wdata;
      dmem_wstrb <= store_wstrb;
    end else if (ack_done) begin
      dmem_req   <= 1'b0;
    end
  end

  // Writeback register: loads return formatted memory data, everything
  // else (including jumps, whose data0 is PC+4) returns the ALU result.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wb_valid <= 1'b0;
      wb_rd    <= 5'd0;
      wb_data  <= 32'h0;
    end else begin
      wb_valid <= wb_write & (wb_reg != 5'd0);
      if (wb_write) begin
        wb_rd   <= wb_reg;
        wb_data <= mem_read ? load_data : mem_data0;
      end
    end
  end

  // Fault pulse and squash flag. A misaligned access never stalls, so the
  // fault naturally lasts a single cycle.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      mem_fault <= 1'b0;
      fault_pc  <= 32'h0;
      squash_q  <= 1'b0;
    end else begin
      mem_fault <= fault_now;
      if (fault_now) begin
        fault_pc <= mem_pc;
      end
      squash_q <= br_taken;
    end
  end

endmodule

// File: tb/tb_stage_memory.sv
// ---------------------------------------------------------------------------
// tb_stage_memory
//
// Self-checking bench for stage_memory. Two tables of directed vectors
// (control-flow/ALU ops and memory ops) with hand-computed expectations,
// followed by hand-written sequences for squash, reset during WAIT and
// back-to-back memory operations.
// ---------------------------------------------------------------------------
module tb_stage_memory;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        mem_valid;
  logic [31:0] mem_pc;
  logic [31:0] mem_data0;
  logic [31:0] mem_data1;
  logic        mem_read;
  logic        mem_write;
  logic        mem_extend;
  logic [1:0]  mem_width;
  logic        mem_jmp;
  logic        mem_br;
  logic        mem_br_inv;
  logic [4:0]  wb_reg;
  logic        mem_stall;
  logic        br_taken;
  logic [31:0] br_target;
  logic        mem_fault;
  logic [31:0] fault_pc;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_wstrb;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  stage_memory dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .mem_valid  (mem_valid),
    .mem_pc     (mem_pc),
    .mem_data0  (mem_data0),
    .mem_data1  (mem_data1),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .mem_extend (mem_extend),
    .mem_width  (mem_width),
    .mem_jmp    (mem_jmp),
    .mem_br     (mem_br),
    .mem_br_inv (mem_br_inv),
    .wb_reg     (wb_reg),
    .mem_stall  (mem_stall),
    .br_taken   (br_taken),
    .br_target  (br_target),
    .mem_fault  (mem_fault),
    .fault_pc   (fault_pc),
    .dmem_req   (dmem_req),
    .dmem_we    (dmem_we),
    .dmem_addr  (dmem_addr),
    .dmem_wdata (dmem_wdata),
    .dmem_wstrb (dmem_wstrb),
    .dmem_ack   (dmem_ack),
    .dmem_rdata (dmem_rdata),
    .wb_valid   (wb_valid),
    .wb_rd      (wb_rd),
    .wb_data    (wb_data)
  );

  typedef struct packed {
    logic        jmp;
    logic        br;
    logic        inv;
    logic [31:0] data0;
    logic [31:0] data1;
    logic [4:0]  rd;
    logic        exp_br;
    logic [31:0] exp_target;
    logic        exp_wb;
    logic [31:0] exp_data;
  } ctrl_vec_t;

  typedef struct packed {
    logic        read;
    logic        write;
    logic        ext;
    logic [1:0]  width;
    logic [31:0] addr;
    logic [31:0] data1;
    logic [4:0]  rd;
    logic [31:0] rdata;
    logic [3:0]  delay;
    logic        exp_fault;
    logic [31:0] exp_addr;
    logic [31:0] exp_wdata;
    logic [3:0]  exp_wstrb;
    logic        exp_wb;
    logic [31:0] exp_data;
  } mem_vec_t;

  localparam int NCTRL = 7;
  localparam int NMEM  = 14;

  ctrl_vec_t ctrlVecs[NCTRL];
  mem_vec_t  memVecs[NMEM];

  function automatic ctrl_vec_t mkCtrl(input logic jmp, input logic br, input logic inv,
                                       input logic [31:0] d0, input logic [31:0] d1,
                                       input logic [4:0] rd, input logic eb,
                                       input logic [31:0] et, input logic ew,
                                       input logic [31:0] ed);
    ctrl_vec_t v;
    v.jmp = jmp; v.br = br; v.inv = inv; v.data0 = d0; v.data1 = d1; v.rd = rd;
    v.exp_br = eb; v.exp_target = et; v.exp_wb = ew; v.exp_data = ed;
    return v;
  endfunction

  function automatic mem_vec_t mkMem(input logic rd_op, input logic wr_op, input logic ext,
                                     input logic [1:0] width, input logic [31:0] addr,
                                     input logic [31:0] d1, input logic [4:0] rd,
                                     input logic [31:0] rdata, input logic [3:0] delay,
                                     input logic ef, input logic [31:0] ea,
                                     input logic [31:0] ewd, input logic [3:0] ews,
                                     input logic ew, input logic [31:0] ed);
    mem_vec_t v;
    v.read = rd_op; v.write = wr_op; v.ext = ext; v.width = width; v.addr = addr;
    v.data1 = d1; v.rd = rd; v.rdata = rdata; v.delay = delay; v.exp_fault = ef;
    v.exp_addr = ea; v.exp_wdata = ewd; v.exp_wstrb = ews; v.exp_wb = ew; v.exp_data = ed;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic valid, input logic rd_op, input logic wr_op,
                               input logic ext, input logic [1:0] width, input logic jmp,
                               input logic br, input logic inv, input logic [31:0] d0,
                               input logic [31:0] d1, input logic [4:0] rd,
                               input logic [31:0] pc);
    mem_valid  = valid;
    mem_read   = rd_op;
    mem_write  = wr_op;
    mem_extend = ext;
    mem_width  = width;
    mem_jmp    = jmp;
    mem_br     = br;
    mem_br_inv = inv;
    mem_data0  = d0;
    mem_data1  = d1;
    wb_reg     = rd;
    mem_pc     = pc;
  endtask

  task automatic applyIdle();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 32'h0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    ctrlVecs[0] = mkCtrl(0, 0, 0, 32'h0000_1234, 32'h0000_0000, 5'd5, 0, 32'h0000_0000, 1, 32'h0000_1234);
    ctrlVecs[1] = mkCtrl(0, 0, 0, 32'hDEAD_BEEF, 32'h0000_0003, 5'd0, 0, 32'h0000_0002, 0, 32'h0);
    ctrlVecs[2] = mkCtrl(1, 0, 0, 32'h0000_0104, 32'h0000_0801, 5'd1, 1, 32'h0000_0800, 1, 32'h0000_0104);
    ctrlVecs[3] = mkCtrl(0, 1, 0, 32'h0000_0001, 32'h0000_0400, 5'd0, 1, 32'h0000_0400, 0, 32'h0);
    ctrlVecs[4] = mkCtrl(0, 1, 0, 32'h0000_0000, 32'h0000_0400, 5'd0, 0, 32'h0000_0400, 0, 32'h0);
    ctrlVecs[5] = mkCtrl(0, 1, 1, 32'h0000_0000, 32'h0000_0123, 5'd0, 1, 32'h0000_0122, 0, 32'h0);
    ctrlVecs[6] = mkCtrl(0, 1, 1, 32'h0000_0001, 32'h0000_0124, 5'd0, 0, 32'h0000_0124, 0, 32'h0);

    memVecs[0]  = mkMem(1, 0, 1, 2'd0, 32'h0000_1003, 32'h0, 5'd3, 32'h80FF_FFFF, 4'd2,
                        0, 32'h0000_1000, 32'h0, 4'h0, 1, 32'hFFFF_FF80);
    memVecs[1]  = mkMem(1, 0, 0, 2'd0, 32'h0000_1001, 32'h0, 5'd4, 32'h1234_5678, 4'd0,
                        0, 32'h0000_1000, 32'h0, 4'h0, 1, 32'h0000_0056);
    memVecs[2]  = mkMem(1, 0, 1, 2'd1, 32'h0000_2002, 32'h0, 5'd5, 32'h8001_7FFF, 4'd1,
                        0, 32'h0000_2000, 32'h0, 4'h0, 1, 32'hFFFF_8001);
    memVecs[3]  = mkMem(1, 0, 0, 2'd1, 32'h0000_2000, 32'h0, 5'd6, 32'h8001_F00F, 4'd0,
                        0, 32'h0000_2000, 32'h0, 4'h0, 1, 32'h0000_F00F);
    memVecs[4]  = mkMem(1, 0, 1, 2'd2, 32'h0000_3004, 32'h0, 5'd7, 32'hCAFE_BABE, 4'd0,
                        0, 32'h0000_3004, 32'h0, 4'h0, 1, 32'hCAFE_BABE);
    memVecs[5]  = mkMem(1, 0, 0, 2'd3, 32'h0000_3008, 32'h0, 5'd8, 32'h1122_3344, 4'd1,
                        0, 32'h0000_3008, 32'h0, 4'h0, 1, 32'h1122_3344);
    memVecs[6]  = mkMem(1, 0, 1, 2'd0, 32'h0000_1002, 32'h0, 5'd9, 32'h007F_0000, 4'd0,
                        0, 32'h0000_1000, 32'h0, 4'h0, 1, 32'h0000_007F);
    memVecs[7]  = mkMem(0, 1, 0, 2'd1, 32'h0000_2002, 32'h5555_ABCD, 5'd7, 32'h0, 4'd0,
                        0, 32'h0000_2000, 32'hABCD_ABCD, 4'b1100, 0, 32'h0);
    memVecs[8]  = mkMem(0, 1, 0, 2'd0, 32'h0000_0012, 32'h0000_00A5, 5'd2, 32'h0, 4'd1,
                        0, 32'h0000_0010, 32'hA5A5_A5A5, 4'b0100, 0, 32'h0);
    memVecs[9]  = mkMem(0, 1, 0, 2'd2, 32'h0000_0020, 32'h0102_0304, 5'd0, 32'h0, 4'd0,
                        0, 32'h0000_0020, 32'h0102_0304, 4'b1111, 0, 32'h0);
    memVecs[10] = mkMem(0, 1, 0, 2'd1, 32'h0000_0030, 32'h1234_9876, 5'd0, 32'h0, 4'd0,
                        0, 32'h0000_0030, 32'h9876_9876, 4'b0011, 0, 32'h0);
    memVecs[11] = mkMem(1, 0, 0, 2'd2, 32'h0000_1001, 32'h0, 5'd3, 32'h0, 4'd0,
                        1, 32'h0, 32'h0, 4'h0, 0, 32'h0);
    memVecs[12] = mkMem(0, 1, 0, 2'd1, 32'h0000_2003, 32'h0, 5'd0, 32'h0, 4'd0,
                        1, 32'h0, 32'h0, 4'h0, 0, 32'h0);
    memVecs[13] = mkMem(1, 0, 0, 2'd3, 32'h0000_1002, 32'h0, 5'd3, 32'h0, 4'd0,
                        1, 32'h0, 32'h0, 4'h0, 0, 32'h0);

    // Reset state
    applyIdle();
    dmem_ack   = 1'b0;
    dmem_rdata = 32'h0;
    reset_n    = 1'b0;
    step();
    step();
    checkOutput("rst_dmem_req", dmem_req, 1'b0);
    checkOutput("rst_wb_valid", wb_valid, 1'b0);
    checkOutput("rst_mem_fault", mem_fault, 1'b0);
    checkOutput("rst_wb_data", wb_data, 32'h0);
    checkOutput("rst_dmem_addr", dmem_addr, 32'h0);
    checkOutput("rst_fault_pc", fault_pc, 32'h0);
    checkOutput("rst_mem_stall", mem_stall, 1'b0);
    checkOutput("rst_br_taken", br_taken, 1'b0);
    reset_n = 1'b1;
    step();

    // Control-flow and ALU vectors, each followed by a bubble
    for (int i = 0; i < NCTRL; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, ctrlVecs[i].jmp, ctrlVecs[i].br,
                    ctrlVecs[i].inv, ctrlVecs[i].data0, ctrlVecs[i].data1,
                    ctrlVecs[i].rd, 32'h100 + 32'(i * 4));
      #1;
      checkOutput($sformatf("ctrl%0d_br_taken", i), br_taken, ctrlVecs[i].exp_br);
      checkOutput($sformatf("ctrl%0d_br_target", i), br_target, ctrlVecs[i].exp_target);
      checkOutput($sformatf("ctrl%0d_stall", i), mem_stall, 1'b0);
      step();
      applyIdle();
      checkOutput($sformatf("ctrl%0d_wb_valid", i), wb_valid, ctrlVecs[i].exp_wb);
      if (ctrlVecs[i].exp_wb) begin
        checkOutput($sformatf("ctrl%0d_wb_rd", i), wb_rd, ctrlVecs[i].rd);
        checkOutput($sformatf("ctrl%0d_wb_data", i), wb_data, ctrlVecs[i].exp_data);
      end
      checkOutput($sformatf("ctrl%0d_dmem_req", i), dmem_req, 1'b0);
      step();
      checkOutput($sformatf("ctrl%0d_wb_after", i), wb_valid, 1'b0);
    end

    // Memory vectors
    for (int i = 0; i < NMEM; i++) begin
      applyStimulus(1'b1, memVecs[i].read, memVecs[i].write, memVecs[i].ext,
                    memVecs[i].width, 1'b0, 1'b0, 1'b0, memVecs[i].addr,
                    memVecs[i].data1, memVecs[i].rd, 32'h800 + 32'(i * 4));
      #1;
      checkOutput($sformatf("mem%0d_br_taken", i), br_taken, 1'b0);
      if (memVecs[i].exp_fault) begin
        checkOutput($sformatf("mem%0d_stall", i), mem_stall, 1'b0);
        step();
        applyIdle();
        checkOutput($sformatf("mem%0d_fault", i), mem_fault, 1'b1);
        checkOutput($sformatf("mem%0d_fault_pc", i), fault_pc, 32'h800 + 32'(i * 4));
        checkOutput($sformatf("mem%0d_no_req", i), dmem_req, 1'b0);
        checkOutput($sformatf("mem%0d_no_wb", i), wb_valid, 1'b0);
        step();
        checkOutput($sformatf("mem%0d_fault_pulse", i), mem_fault, 1'b0);
        checkOutput($sformatf("mem%0d_no_req_late", i), dmem_req, 1'b0);
      end else begin
        checkOutput($sformatf("mem%0d_stall_first", i), mem_stall, 1'b1);
        step();
        checkOutput($sformatf("mem%0d_req", i), dmem_req, 1'b1);
        checkOutput($sformatf("mem%0d_addr", i), dmem_addr, memVecs[i].exp_addr);
        checkOutput($sformatf("mem%0d_we", i), dmem_we, memVecs[i].write);
        if (memVecs[i].write) begin
          checkOutput($sformatf("mem%0d_wdata", i), dmem_wdata, memVecs[i].exp_wdata);
          checkOutput($sformatf("mem%0d_wstrb", i), dmem_wstrb, memVecs[i].exp_wstrb);
        end
        for (int d = 0; d < int'(memVecs[i].delay); d++) begin
          #1;
          checkOutput($sformatf("mem%0d_stall_wait%0d", i, d), mem_stall, 1'b1);
          step();
          checkOutput($sformatf("mem%0d_req_hold%0d", i, d), dmem_req, 1'b1);
          checkOutput($sformatf("mem%0d_addr_hold%0d", i, d), dmem_addr, memVecs[i].exp_addr);
        end
        dmem_ack   = 1'b1;
        dmem_rdata = memVecs[i].rdata;
        #1;
        checkOutput($sformatf("mem%0d_stall_ack", i), mem_stall, 1'b0);
        step();
        dmem_ack   = 1'b0;
        dmem_rdata = 32'h0;
        applyIdle();
        checkOutput($sformatf("mem%0d_req_drop", i), dmem_req, 1'b0);
        checkOutput($sformatf("mem%0d_wb_valid", i), wb_valid, memVecs[i].exp_wb);
        if (memVecs[i].exp_wb) begin
          checkOutput($sformatf("mem%0d_wb_rd", i), wb_rd, memVecs[i].rd);
          checkOutput($sformatf("mem%0d_wb_data", i), wb_data, memVecs[i].exp_data);
        end
        step();
        checkOutput($sformatf("mem%0d_no_reissue", i), dmem_req, 1'b0);
        checkOutput($sformatf("mem%0d_wb_once", i), wb_valid, 1'b0);
      end
    end

    // Taken branch squashes the load that follows it
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0,
                  32'h1, 32'h500, 5'd0, 32'h200);
    #1;
    checkOutput("sq_br_taken", br_taken, 1'b1);
    checkOutput("sq_br_target", br_target, 32'h500);
    step();
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 2'd2, 1'b0, 1'b0, 1'b0,
                  32'h1000, 32'h0, 5'd4, 32'h204);
    #1;
    checkOutput("sq_load_stall", mem_stall, 1'b0);
    checkOutput("sq_load_br", br_taken, 1'b0);
    step();
    applyIdle();
    checkOutput("sq_load_req", dmem_req, 1'b0);
    checkOutput("sq_load_wb", wb_valid, 1'b0);
    step();
    checkOutput("sq_load_req_late", dmem_req, 1'b0);

    // Jump followed by a jump: follower is killed, no redirect, no writeback
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0,
                  32'h304, 32'h600, 5'd1, 32'h300);
    #1;
    checkOutput("sqj_br_taken", br_taken, 1'b1);
    step();
    checkOutput("sqj_wb_valid", wb_valid, 1'b1);
    checkOutput("sqj_wb_data", wb_data, 32'h304);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0,
                  32'h999, 32'h700, 5'd2, 32'h304);
    #1;
    checkOutput("sqj_follow_br", br_taken, 1'b0);
    step();
    applyIdle();
    checkOutput("sqj_follow_wb", wb_valid, 1'b0);
    step();

    // Reset while waiting abandons the request
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 2'd2, 1'b0, 1'b0, 1'b0,
                  32'h4000, 32'h0, 5'd6, 32'h400);
    step();
    checkOutput("rw_req", dmem_req, 1'b1);
    applyIdle();
    reset_n = 1'b0;
    step();
    checkOutput("rw_req_drop", dmem_req, 1'b0);
    checkOutput("rw_wb_valid", wb_valid, 1'b0);
    reset_n  = 1'b1;
    dmem_ack = 1'b1;
    dmem_rdata = 32'hBAD0_BAD0;
    step();
    dmem_ack = 1'b0;
    checkOutput("rw_stray_ack_wb", wb_valid, 1'b0);
    checkOutput("rw_stray_ack_req", dmem_req, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 2'd2, 1'b0, 1'b0, 1'b0,
                  32'h4004, 32'h0, 5'd6, 32'h404);
    #1;
    checkOutput("rw_new_stall", mem_stall, 1'b1);
    step();
    checkOutput("rw_new_req", dmem_req, 1'b1);
    checkOutput("rw_new_addr", dmem_addr, 32'h4004);
    dmem_ack   = 1'b1;
    dmem_rdata = 32'h0000_0077;
    step();
    dmem_ack = 1'b0;
    applyIdle();
    checkOutput("rw_new_wb", wb_valid, 1'b1);
    checkOutput("rw_new_data", wb_data, 32'h0000_0077);
    step();

    // Back-to-back loads: the second instruction sees IDLE after the ack
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 2'd2, 1'b0, 1'b0, 1'b0,
                  32'h5000, 32'h0, 5'd8, 32'h500);
    step();
    checkOutput("b2b_req_a", dmem_req, 1'b1);
    dmem_ack   = 1'b1;
    dmem_rdata = 32'h0000_000A;
    step();
    dmem_ack = 1'b0;
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 2'd2, 1'b0, 1'b0, 1'b0,
                  32'h5008, 32'h0, 5'd9, 32'h504);
    checkOutput("b2b_wb_a", wb_valid, 1'b1);
    checkOutput("b2b_data_a", wb_data, 32'h0000_000A);
    checkOutput("b2b_req_gap", dmem_req, 1'b0);
    #1;
    checkOutput("b2b_stall_b", mem_stall, 1'b1);
    step();
    checkOutput("b2b_req_b", dmem_req, 1'b1);
    checkOutput("b2b_addr_b", dmem_addr, 32'h5008);
    checkOutput("b2b_wb_gap", wb_valid, 1'b0);
    dmem_ack   = 1'b1;
    dmem_rdata = 32'h0000_000B;
    step();
    dmem_ack = 1'b0;
    applyIdle();
    checkOutput("b2b_wb_b", wb_valid, 1'b1);
    checkOutput("b2b_rd_b", wb_rd, 5'd9);
    checkOutput("b2b_data_b", wb_data, 32'h0000_000B);
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
